// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter of the two-stage core.
// The NOP constant is also used by decode to fill bubbles.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        IF_DROP = 2'd3
    } arb_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          TIMER_W   = 8;

endpackage

// File: rtl/access_timer.sv
// Busy-cycle counter for one memory access; tc marks the cycle in which the
// TIMEOUT-th consecutive not-ready busy cycle is being spent.
module access_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = en && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one single-ported memory,
// with flush handling, a data-burst starvation guard and an access timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT     = 64,
    parameter int MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        err
);

    arb_state_t state, state_nx;
    logic [3:0] burst_cnt, burst_nx;
    logic       d_grant, f_grant, starve;
    logic       busy, tmo, tmr_clr;

    assign busy    = (state != IDLE);
    assign tmr_clr = (state_nx != state);

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (busy && !mem_ready),
        .tc  (tmo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            burst_cnt <= burst_nx;
        end
    end

    // The cycle a done pulse is visible the requester still holds its request,
    // so arbitration waits one cycle to avoid re-granting the finished access.
    always_comb begin
        state_nx = state;
        burst_nx = burst_cnt;
        d_grant  = 1'b0;
        f_grant  = 1'b0;
        starve   = (burst_cnt == 4'(MAX_D_BURST)) && if_req && !flush;
        case (state)
            IDLE: begin
                if (!if_req)
                    burst_nx = '0;
                if (!(if_done || d_done)) begin
                    if (d_req && !starve) begin
                        d_grant  = 1'b1;
                        state_nx = D_BUSY;
                        if (if_req && burst_cnt != 4'(MAX_D_BURST))
                            burst_nx = burst_cnt + 4'd1;
                    end else if (if_req && !flush) begin
                        f_grant  = 1'b1;
                        state_nx = IF_BUSY;
                        burst_nx = '0;
                    end
                end
            end
            IF_BUSY: begin
                if (mem_ready || tmo)
                    state_nx = IDLE;
                else if (flush)
                    state_nx = IF_DROP;
            end
            default: begin
                if (mem_ready || tmo)
                    state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= NOP_INSTR;
            d_rdata   <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            if (d_grant) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
            end else if (f_grant) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wstrb <= '0;
            end else if (busy && (mem_ready || tmo)) begin
                mem_req <= 1'b0;
            end
            case (state)
                IF_BUSY: begin
                    // A flush arriving with the completion still discards the fetch.
                    if (mem_ready) begin
                        if (!flush) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else if (tmo) begin
                        err <= 1'b1;
                        if (!flush) begin
                            if_done  <= 1'b1;
                            if_rdata <= NOP_INSTR;
                        end
                    end
                end
                D_BUSY: begin
                    if (mem_ready) begin
                        d_done <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end else if (tmo) begin
                        err     <= 1'b1;
                        d_done  <= 1'b1;
                        d_rdata <= '0;
                    end
                end
                IF_DROP: begin
                    if (tmo)
                        err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall = (d_req & ~d_done) | (if_req & ~flush & ~if_done);

endmodule
